// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-channel frame serializer with valid/ready output.
// Captures NUM_CH words in one handshake and emits them in channel order,
// with back-pressure, out_last framing and zero-bubble frame reload.
// Optional: RR_STREAM_MUX_CH_MASK_EN adds in_mask to skip channels.
module rr_stream_mux #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned NUM_CH = 4,
  localparam int unsigned SEL_W = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
`ifdef RR_STREAM_MUX_CH_MASK_EN
  input  logic [NUM_CH-1:0]       in_mask,
`endif
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_last,
  output logic                    busy
);

  typedef enum logic {StIdle, StStream} state_e;

  state_e                        r_state, w_state_nxt;
  logic [NUM_CH-1:0][WIDTH-1:0]  r_buf, w_buf_nxt;
  logic [SEL_W-1:0]              r_sel, w_sel_nxt;

  logic [SEL_W-1:0] w_first;     // channel to start a newly captured frame on
  logic [SEL_W-1:0] w_next;      // channel following r_sel within the frame
  logic [SEL_W-1:0] w_high;      // final channel of the captured frame
  logic             w_frame_en;  // captured frame has at least one word
  logic             w_last;
  logic             w_load;

`ifdef RR_STREAM_MUX_CH_MASK_EN
  logic [NUM_CH-1:0] r_mask, w_mask_nxt;

  // Locate lowest enabled channel of the incoming mask and the next/highest of the held one.
  always_comb begin
    w_first = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (in_mask[i]) w_first = SEL_W'(i);
    end
    w_next = r_sel;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (r_mask[i] && (i > int'(r_sel))) w_next = SEL_W'(i);
    end
    w_high = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_mask[i]) w_high = SEL_W'(i);
    end
  end

  assign w_frame_en = |in_mask;
`else
  assign w_first    = '0;
  assign w_next     = r_sel + SEL_W'(1);
  assign w_high     = SEL_W'(NUM_CH - 1);
  assign w_frame_en = 1'b1;
`endif

  assign w_last   = (r_state == StStream) && (r_sel == w_high);
  assign in_ready = (r_state == StIdle) || (w_last && out_ready);
  assign w_load   = in_valid && in_ready;

  // Outputs come from registers only; no input-to-output combinational path.
  assign out_valid = (r_state == StStream);
  assign busy      = (r_state == StStream);
  assign out_data  = r_buf[r_sel];
  assign out_ch    = r_sel;
  assign out_last  = w_last;

  // Next-state: advance on transfers, reload on accept (also on the last-word edge).
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_buf_nxt   = r_buf;
`ifdef RR_STREAM_MUX_CH_MASK_EN
    w_mask_nxt  = r_mask;
`endif
    unique case (r_state)
      StIdle: begin
      end
      StStream: begin
        if (out_ready) begin
          if (w_last) w_state_nxt = StIdle;
          else        w_sel_nxt   = w_next;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
    if (w_load) begin
      w_buf_nxt   = in_data;
      w_sel_nxt   = w_first;
      w_state_nxt = w_frame_en ? StStream : StIdle;
`ifdef RR_STREAM_MUX_CH_MASK_EN
      w_mask_nxt  = in_mask;
`endif
    end
  end

  // State and frame registers; async reset discards any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_sel   <= '0;
      r_buf   <= '0;
`ifdef RR_STREAM_MUX_CH_MASK_EN
      r_mask  <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_buf   <= w_buf_nxt;
`ifdef RR_STREAM_MUX_CH_MASK_EN
      r_mask  <= w_mask_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Bench for rr_stream_mux: queue-based reference model for a 4-channel
// instance plus literal stream checks; a 3-channel instance covers wrap.
module tb_rr_stream_mux;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4*W-1:0] in_data = '0;
  logic [3:0]    in_mask = 4'hF;
  logic          in_valid = 1'b0, in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid, out_last, busy;
  logic          out_ready = 1'b1;
  logic [1:0]    out_ch;

  logic [3*W-1:0] in_data3 = '0;
  logic          in_valid3 = 1'b0, in_ready3;
  logic [W-1:0]  out_data3;
  logic          out_valid3, out_last3, busy3;
  logic          out_ready3 = 1'b1;
  logic [1:0]    out_ch3;
`ifdef RR_STREAM_MUX_CH_MASK_EN
  logic [2:0]    in_mask3 = 3'b111;
`endif

  rr_stream_mux #(.WIDTH(W), .NUM_CH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data),
`ifdef RR_STREAM_MUX_CH_MASK_EN
    .in_mask(in_mask),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_last(out_last), .busy(busy)
  );

  rr_stream_mux #(.WIDTH(W), .NUM_CH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3),
`ifdef RR_STREAM_MUX_CH_MASK_EN
    .in_mask(in_mask3),
`endif
    .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_ch(out_ch3),
    .out_last(out_last3), .busy(busy3)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {logic [15:0] d; int ch; logic last; int cyc;} word_t;
  word_t mq[$];     // words the block still owes, front = currently presented
  word_t rec[$];    // transfers seen on dut
  word_t rec3[$];   // transfers seen on dut3
  logic [15:0] expd[$];
  int          expch[$];
  logic        explast[$];

  logic        s_valid, s_last, s_valid3, s_last3;
  logic [15:0] s_data, s_data3;
  logic [1:0]  s_ch, s_ch3;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model: a frame becomes a list of the enabled channels' words, last on the final one.
  task automatic push_frame(input logic [4*W-1:0] d, input logic [3:0] m);
    int hi;
    word_t w;
    hi = -1;
    for (int k = 0; k < 4; k++) if (m[k]) hi = k;
    for (int k = 0; k < 4; k++) begin
      if (m[k]) begin
        w.d = d[k*W +: W]; w.ch = k; w.last = (k == hi); w.cyc = 0;
        mq.push_back(w);
      end
    end
  endtask

  // Model update and transfer recording at each rising edge.
  always @(posedge clk) begin
    bit    inr;
    word_t w;
    cyc++;
    if (rst_n && s_valid && out_ready) begin
      w.d = s_data; w.ch = int'(s_ch); w.last = s_last; w.cyc = cyc;
      rec.push_back(w);
    end
    if (rst_n && s_valid3 && out_ready3) begin
      w.d = s_data3; w.ch = int'(s_ch3); w.last = s_last3; w.cyc = cyc;
      rec3.push_back(w);
    end
    if (!rst_n) mq.delete();
    else begin
      inr = (mq.size() == 0) || (mq[0].last && out_ready);
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (in_valid && inr) push_frame(in_data, in_mask);
    end
  end

  always @(negedge rst_n) mq.delete();

  // Compare process: every falling edge out of reset, DUT against model.
  always @(negedge clk) begin
    bit ev, er;
    s_valid = out_valid; s_data = out_data; s_ch = out_ch; s_last = out_last;
    s_valid3 = out_valid3; s_data3 = out_data3; s_ch3 = out_ch3; s_last3 = out_last3;
    if (rst_n) begin
      ev = (mq.size() > 0);
      er = ev ? (mq[0].last && out_ready) : 1'b1;
      chk("out_valid", out_valid, ev);
      chk("busy", busy, ev);
      chk("in_ready", in_ready, er);
      if (ev) begin
        chk("out_data", out_data, mq[0].d);
        chk("out_ch", out_ch, mq[0].ch);
        chk("out_last", out_last, mq[0].last);
      end
      if (out_valid3) chk("out_ch3_range", out_ch3 < 2'd3, 1);
    end
  end

  task automatic send4(input logic [4*W-1:0] d, input logic [3:0] m, output int acc);
    bit got;
    got = 1'b0;
    in_data = d; in_mask = m; in_valid = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk); got = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_mask = 4'hF;
    acc = cyc;
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL send4: in_ready got 0 required 1 within 200 cycles");
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk); done = !out_valid;
      @(posedge clk); #1;
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL wait_idle: out_valid got 1 required 0 within 200 cycles");
    end
  endtask

  // Check recorded transfers against literal expectations; first_cyc<0 skips timing.
  task automatic chk_stream(input string tag, input int first_cyc, input bit three);
    int n;
    n = three ? rec3.size() : rec.size();
    chk({tag, "_count"}, n, expd.size());
    for (int i = 0; i < expd.size() && i < n; i++) begin
      word_t w;
      w = three ? rec3[i] : rec[i];
      chk({tag, "_data"}, w.d, expd[i]);
      chk({tag, "_ch"}, w.ch, expch[i]);
      chk({tag, "_last"}, w.last, explast[i]);
      if (first_cyc >= 0) chk({tag, "_cycle"}, w.cyc, first_cyc + i);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [4*W-1:0] FrmAbcd = {16'h000D, 16'h000C, 16'h000B, 16'h000A};
  localparam logic [4*W-1:0] Frm1234 = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
  localparam logic [4*W-1:0] Frm9999 = {16'h0009, 16'h0009, 16'h0009, 16'h0009};

  initial begin
    int acc, acc2;
    // Reset values
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ch", out_ch, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("rst_in_ready", in_ready, 1);

    // Single frame, out_ready high, idle out_ready has no effect
    rec.delete();
    send4(FrmAbcd, 4'hF, acc);
    wait_idle();
    expd = '{16'hA, 16'hB, 16'hC, 16'hD}; expch = '{0, 1, 2, 3}; explast = '{0, 0, 0, 1};
    chk_stream("single", acc + 1, 1'b0);
    chk("single_in_ready_idle", in_ready, 1);

    // Back-pressure on B for three cycles
    rec.delete();
    send4(FrmAbcd, 4'hF, acc);
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_data", out_data, 16'hB);
      chk("bp_hold_ch", out_ch, 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_idle();
    chk_stream("bp", -1, 1'b0);

    // Back-to-back frames with no bubble
    rec.delete();
    send4(FrmAbcd, 4'hF, acc);
    send4(Frm1234, 4'hF, acc2);
    wait_idle();
    expd = '{16'hA, 16'hB, 16'hC, 16'hD, 16'h1, 16'h2, 16'h3, 16'h4};
    expch = '{0, 1, 2, 3, 0, 1, 2, 3};
    explast = '{0, 0, 0, 1, 0, 0, 0, 1};
    chk_stream("b2b", acc + 1, 1'b0);
    chk("b2b_accept_cycle", acc2, acc + 4);

    // Non-power-of-two channel count
    in_data3 = {16'h0007, 16'h0006, 16'h0005};
    in_valid3 = 1'b1;
    @(posedge clk); #1;
    in_valid3 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    expd = '{16'h5, 16'h6, 16'h7}; expch = '{0, 1, 2}; explast = '{0, 0, 1};
    chk_stream("ch3", -1, 1'b1);
    chk("ch3_idle_valid", out_valid3, 0);

    // Asynchronous reset mid-frame, after B is presented
    send4(FrmAbcd, 4'hF, acc);
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_out_last", out_last, 0);
    chk("arst_out_ch", out_ch, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    rec.delete();
    send4(Frm9999, 4'hF, acc);
    wait_idle();
    expd = '{16'h9, 16'h9, 16'h9, 16'h9}; expch = '{0, 1, 2, 3}; explast = '{0, 0, 0, 1};
    chk_stream("arst_new", acc + 1, 1'b0);

`ifdef RR_STREAM_MUX_CH_MASK_EN
    // Channel mask skipping 0 and 2
    rec.delete();
    send4(FrmAbcd, 4'b1010, acc);
    wait_idle();
    expd = '{16'hB, 16'hD}; expch = '{1, 3}; explast = '{0, 1};
    chk_stream("mask1010", acc + 1, 1'b0);

    // All-zero mask from IDLE: dropped, stays idle
    rec.delete();
    send4(FrmAbcd, 4'b0000, acc);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mask0_out_valid", out_valid, 0);
      chk("mask0_in_ready", in_ready, 1);
    end
    // All-zero mask on back-to-back reload: returns to IDLE
    send4(FrmAbcd, 4'hF, acc);
    send4(Frm1234, 4'b0000, acc2);
    wait_idle();
    expd = '{16'hA, 16'hB, 16'hC, 16'hD}; expch = '{0, 1, 2, 3}; explast = '{0, 0, 0, 1};
    chk_stream("mask0_b2b", acc + 1, 1'b0);
`endif

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Parametrised N-channel frame serializer: captures a frame of NUM_CH words (one per RAM bank) in a single handshake.
- Emits the captured words one per transfer, in channel order 0..NUM_CH-1, on a valid/ready output stream.
- Sits between the parallel RAM read ports and the single MAC input.
- Replaces the free-running 4:1 mux with back-pressure, frame delimiting and back-to-back frame reload.

Parameters:
- WIDTH, 16, bits per channel word.
- NUM_CH, 4, number of input channels; legal range 2..64, need not be a power of two.
- SEL_W, $clog2(NUM_CH), channel index width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_data  input  NUM_CH*WIDTH  frame; channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  1  frame available.
- in_ready  output  1  block can accept a frame this cycle.
- out_data  output  WIDTH  current word.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts word.
- out_ch  output  SEL_W  channel index of out_data.
- out_last  output  1  high with final word of the frame.
- busy  output  1  high while in STREAM.

Behaviour:
- Clock and reset: one clock domain (clk). rst_n is asynchronous and active-low.
- Reset state:
  - state=IDLE; frame buffer, sel, out_ch, out_data all 0.
  - out_valid=0, out_last=0, busy=0, in_ready=1 once reset is released.
- FSM has two states, IDLE and STREAM.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: latch all NUM_CH words into the frame buffer, sel<=0, go to STREAM.
- STREAM:
  - out_valid=1, busy=1, out_data=buffer[sel], out_ch=sel, out_last=(sel==NUM_CH-1).
  - out_data/out_ch/out_last are decoded from registers only; no combinational path from inputs.
- Latency: word 0 is presented on the cycle after the frame-accept edge.
- Transfer rule:
  - A transfer occurs on a clock edge where out_valid&out_ready is high.
  - On a non-last transfer, sel<=sel+1.
  - While out_valid&!out_ready, out_data, out_ch and out_last hold stable; sel never advances.
- in_ready = (state==IDLE) | (state==STREAM & out_last & out_ready).
- Last-word transfer:
  - If in_valid is also high in the same cycle, the new frame is latched, sel<=0, state stays STREAM. The next frame follows with zero bubble cycles.
  - Otherwise go to IDLE; out_valid drops the next cycle.
- in_valid while STREAM and not on a last transfer: ignored (in_ready=0), buffer unchanged. Upstream must hold in_valid high.
- Wrap: sel wraps at NUM_CH-1 for any NUM_CH. No index >= NUM_CH is ever used, including for non-power-of-two NUM_CH.
- out_ready high in IDLE: no effect.
- Reset mid-frame: the frame is discarded immediately; outputs return to reset values with no partial out_last.
- Throughput: 1 word/cycle with out_ready tied high, so a NUM_CH-word frame takes NUM_CH cycles.

Optional Feature:
- Macro: RR_STREAM_MUX_CH_MASK_EN.
- Defined:
  - Adds port in_mask (input, NUM_CH bits), captured together with in_data.
  - Masked-off channels are skipped: sel starts at the lowest enabled channel and advances to the next enabled channel.
  - out_last is asserted on the highest enabled channel.
  - An all-zero mask accepts and drops the frame; no words are emitted. From IDLE the block stays in IDLE. On a back-to-back reload it goes to IDLE.
  - A skip costs no extra cycles.
- Undefined: no in_mask port; every channel is emitted.

Test Plan:
- Reset, single frame: NUM_CH=4, frame {0x000A,0x000B,0x000C,0x000D}, out_ready=1 -> out_data A,B,C,D on 4 consecutive cycles starting 1 cycle after accept; out_ch 0..3; out_last only with D; then IDLE, in_ready=1.
- Back-pressure: out_ready low 3 cycles while B is presented -> B and out_ch=1 held stable for 3 cycles; no word lost or duplicated.
- Back-to-back frames: second frame {1,2,3,4} held valid during the first frame -> accepted on D's transfer cycle; output stream is A,B,C,D,1,2,3,4 with no gap.
- Non-power-of-two: NUM_CH=3, frame {5,6,7} -> 5,6,7 with out_last on 7; out_ch never equals 3.
- Async reset mid-frame: assert rst_n low between clock edges after B -> out_valid=0, busy=0 immediately; after release, a new frame {9,9,9,9} streams from channel 0.
- Mask (RR_STREAM_MUX_CH_MASK_EN defined):
  - Mask 4'b1010 with frame {A,B,C,D} -> B then D, out_last on D.
  - Mask 4'b0000 -> no out_valid pulse; in_ready remains 1.
